// File: rtl/wsb_pkg.sv
// Shared definitions for the WS2812B frame transmitter: FSM encoding and
// default bit timing in 100 MHz clk cycles.
package wsb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RET,
    ST_FETCH,
    ST_SEND,
    ST_DONE
  } wsb_state_e;

  localparam int WSB_TBIT = 125;
  localparam int WSB_T0H  = 40;
  localparam int WSB_T1H  = 80;

  localparam int         PIX_W    = 24;
  localparam logic [4:0] LAST_BIT = 5'd23;

endpackage

// File: rtl/wsb_bit_gen.sv
// One WS2812B bit cell: TBIT cycles long, high for T1H (one) or T0H (zero).
// The counter free-runs while go is held, so back-to-back bits are seamless.
module wsb_bit_gen
  import wsb_pkg::*;
#(
  parameter int TBIT = WSB_TBIT,
  parameter int T0H  = WSB_T0H,
  parameter int T1H  = WSB_T1H
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic bitVal,
  output logic dout,
  output logic bitDone
);

  localparam logic [7:0] CNT_LAST = 8'(TBIT - 1);
  localparam logic [7:0] HI0      = 8'(T0H);
  localparam logic [7:0] HI1      = 8'(T1H);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!go || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign bitDone = go && (cnt == CNT_LAST);
  assign dout    = go && (cnt < (bitVal ? HI1 : HI0));

endmodule

// File: rtl/wsb_frame_tx.sv
// WS2812B frame transmitter: RET wait, then NUM_LEDS GRB pixels shifted
// MSB-first, with a one-entry holding register between pixels.
module wsb_frame_tx
  import wsb_pkg::*;
#(
  parameter int TBIT     = WSB_TBIT,
  parameter int T0H      = WSB_T0H,
  parameter int T1H      = WSB_T1H,
  parameter int NUM_LEDS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              retEn,
  input  logic              retDone,
  input  logic [PIX_W-1:0]  pixData,
  input  logic              pixValid,
  output logic              pixReady,
  output logic              dout,
  output logic              busy,
  output logic              frameDone,
  output logic              underrun
);

  localparam logic [7:0] LAST_PIX = 8'(NUM_LEDS - 1);
  localparam logic       MULTI    = (NUM_LEDS > 1);

  wsb_state_e       state;
  logic [7:0]       pixCnt;
  logic [4:0]       bitIdx;
  logic [PIX_W-1:0] shiftReg;
  logic [PIX_W-1:0] holdReg;
  logic             holdFull;
  logic             bitDone;
  logic             xfer;
  logic             lastPix;
  logic             lastBit;

  assign xfer    = pixValid && pixReady;
  assign lastPix = (pixCnt == LAST_PIX);
  assign lastBit = (bitIdx == LAST_BIT);

  wsb_bit_gen #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_bit_gen (
    .clk     (clk),
    .reset   (reset),
    .go      (state == ST_SEND),
    .bitVal  (shiftReg[PIX_W-1]),
    .dout    (dout),
    .bitDone (bitDone)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pixCnt    <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      holdReg   <= '0;
      holdFull  <= 1'b0;
      retEn     <= 1'b0;
      pixReady  <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      underrun  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RET;
            retEn    <= 1'b1;
            busy     <= 1'b1;
            pixCnt   <= '0;
            bitIdx   <= '0;
            holdFull <= 1'b0;
          end
        end
        ST_RET: begin
          if (retDone) begin
            state    <= ST_FETCH;
            retEn    <= 1'b0;
            pixReady <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (xfer) begin
            state    <= ST_SEND;
            shiftReg <= pixData;
            bitIdx   <= '0;
            pixReady <= MULTI;
          end
        end
        ST_SEND: begin
          if (bitDone && lastBit) begin
            bitIdx <= '0;
            if (lastPix) begin
              state     <= ST_DONE;
              frameDone <= 1'b1;
              pixReady  <= 1'b0;
            end else if (holdFull || xfer) begin
              // a transfer landing on this same edge counts as a full holding register
              shiftReg <= holdFull ? holdReg : pixData;
              holdFull <= 1'b0;
              pixCnt   <= pixCnt + 8'd1;
              pixReady <= ((pixCnt + 8'd1) != LAST_PIX);
            end else begin
              state    <= ST_IDLE;
              underrun <= 1'b1;
              busy     <= 1'b0;
              pixReady <= 1'b0;
            end
          end else begin
            if (bitDone) begin
              shiftReg <= {shiftReg[PIX_W-2:0], 1'b0};
              bitIdx   <= bitIdx + 5'd1;
            end
            if (xfer) begin
              holdReg  <= pixData;
              holdFull <= 1'b1;
              pixReady <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wsb_frame_tx.sv
// Bench for wsb_frame_tx: one-pixel and three-pixel instances, a scoreboard of
// expected bit shapes and frame events, and a monitor decoding the serial line.
module tb_wsb_frame_tx;

  localparam int EV_BIT = 0;
  localparam int EV_FD  = 1;
  localparam int EV_UR  = 2;

  typedef struct {
    int kind;
    int hi;
    int lo;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   xc [2] = '{0, 0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0]       st = '0;
  logic [1:0]       rd = '0;
  logic [1:0]       pv = '0;
  logic [1:0][23:0] pd = '0;
  logic [1:0]       re, pr, dq, bz, fd, ur;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++)
      if (pv[d] && pr[d]) xc[d] <= xc[d] + 1;
  end

  wsb_frame_tx #(.TBIT(125), .T0H(40), .T1H(80), .NUM_LEDS(1)) u_one (
    .clk(clk), .reset(reset), .start(st[0]), .retEn(re[0]), .retDone(rd[0]),
    .pixData(pd[0]), .pixValid(pv[0]), .pixReady(pr[0]), .dout(dq[0]),
    .busy(bz[0]), .frameDone(fd[0]), .underrun(ur[0])
  );

  wsb_frame_tx #(.TBIT(125), .T0H(40), .T1H(80), .NUM_LEDS(3)) u_three (
    .clk(clk), .reset(reset), .start(st[1]), .retEn(re[1]), .retDone(rd[1]),
    .pixData(pd[1]), .pixValid(pv[1]), .pixReady(pr[1]), .dout(dq[1]),
    .busy(bz[1]), .frameDone(fd[1]), .underrun(ur[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pix(input logic [23:0] px, input int nbits);
    exp_t e;
    for (int i = 23; i > 23 - nbits; i--) begin
      e.kind = EV_BIT;
      e.hi   = px[i] ? 80 : 40;
      e.lo   = px[i] ? 45 : 85;
      sb.push_back(e);
    end
  endtask

  task automatic push_ev(input int kind);
    exp_t e;
    e.kind = kind;
    e.hi   = 0;
    e.lo   = 0;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input int hi, input int lo);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_output", kind, -1);
      return;
    end
    e = sb.pop_front();
    chk("sb_kind", kind, e.kind);
    if (kind == EV_BIT && e.kind == EV_BIT)
      chk("sb_bit_hi_lo", hi * 1000 + lo, e.hi * 1000 + e.lo);
  endtask

  // Line decoder: a bit ends at the next rising edge or at a frame event.
  logic md;
  logic mprev = 1'b0;
  bit   inb = 1'b0;
  int   mhi = 0;
  int   mlo = 0;

  always @(negedge clk) begin
    if (!reset) begin
      inb = 1'b0; mhi = 0; mlo = 0; mprev = 1'b0;
    end else if ((|fd) || (|ur)) begin
      if (inb) pop_chk(EV_BIT, mhi, mlo);
      inb = 1'b0; mprev = 1'b0;
      pop_chk((|fd) ? EV_FD : EV_UR, 0, 0);
    end else begin
      md = |dq;
      if (md && !mprev) begin
        if (inb) pop_chk(EV_BIT, mhi, mlo);
        inb = 1'b1; mhi = 1; mlo = 0;
      end else if (md) begin
        mhi++;
      end else if (inb) begin
        mlo++;
      end
      mprev = md;
    end
  end

  task automatic begin_frame(input int d, input int delay);
    int cnt = 0;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (re[d]) cnt++;
      if (i == delay - 1) rd[d] = 1'b1;
      @(negedge clk);
    end
    rd[d] = 1'b0;
    chk("ret_en_cycles", cnt, delay);
    chk("ret_en_after_done", int'(re[d]), 0);
    chk("fetch_pix_ready", int'(pr[d]), 1);
  endtask

  task automatic send_pix(input int d, input logic [23:0] px, input int bound, input bit keep);
    int n = 0;
    pd[d] = px;
    pv[d] = 1'b1;
    while (!pr[d] && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) chk("pix_accept_timeout", n, -1);
    @(negedge clk);
    if (!keep) pv[d] = 1'b0;
  endtask

  task automatic wait_pulse(input int d, input bit want_ur, input int bound);
    int n = 0;
    while (!(want_ur ? ur[d] : fd[d]) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) chk(want_ur ? "underrun_timeout" : "frame_done_timeout", n, -1);
  endtask

  initial begin : stim
    int t0;
    int xb;

    repeat (3) @(negedge clk);
    chk("reset_outputs_one", int'({re[0], pr[0], dq[0], bz[0], fd[0], ur[0]}), 0);
    chk("reset_outputs_three", int'({re[1], pr[1], dq[1], bz[1], fd[1], ur[1]}), 0);
    #2 reset = 1'b1;
    @(negedge clk);

    // RET wait of 6000 cycles, then a single pixel 24'hA50000
    begin_frame(0, 6000);
    push_pix(24'hA50000, 24);
    push_ev(EV_FD);
    send_pix(0, 24'hA50000, 10, 1'b0);
    t0 = cyc;
    chk("one_busy_in_send", int'(bz[0]), 1);
    wait_pulse(0, 1'b0, 3500);
    chk("one_frame_len", cyc - t0, 3000);
    chk("one_busy_in_done", int'(bz[0]), 1);
    @(negedge clk);
    chk("one_idle_after_done", int'({bz[0], fd[0], dq[0]}), 0);

    // start pulsed mid-frame is ignored
    begin_frame(0, 50);
    push_pix(24'h00FF00, 24);
    push_ev(EV_FD);
    send_pix(0, 24'h00FF00, 10, 1'b0);
    t0 = cyc;
    repeat (1000) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("mid_start_no_ret", int'(re[0]), 0);
    wait_pulse(0, 1'b0, 3500);
    chk("mid_start_frame_len", cyc - t0, 3000);
    repeat (5) @(negedge clk);
    chk("mid_start_stays_idle", int'({re[0], bz[0]}), 0);

    // second pixel withheld: underrun at the end of pixel 0
    begin_frame(1, 10);
    push_pix(24'h5A0F3C, 24);
    push_ev(EV_UR);
    send_pix(1, 24'h5A0F3C, 10, 1'b0);
    t0 = cyc;
    wait_pulse(1, 1'b1, 4000);
    chk("underrun_time", cyc - t0, 3000);
    chk("underrun_line_idle", int'({dq[1], bz[1], fd[1]}), 0);
    @(negedge clk);
    chk("underrun_single_pulse", int'({ur[1], pr[1], bz[1]}), 0);

    // reset during bit 10 of pixel 1
    begin_frame(1, 10);
    push_pix(24'hC33C81, 24);
    push_pix(24'h7E0180, 10);
    send_pix(1, 24'hC33C81, 10, 1'b0);
    t0 = cyc;
    send_pix(1, 24'h7E0180, 10, 1'b0);
    repeat (4280 - (cyc - t0)) @(negedge clk);
    chk("pre_reset_active", int'({dq[1], bz[1]}), 3);
    #2 reset = 1'b0;
    #1 chk("async_reset_outputs", int'({re[1], pr[1], dq[1], bz[1], fd[1], ur[1]}), 0);
    repeat (3) @(negedge clk);
    chk("reset_hold_outputs", int'({re[1], pr[1], dq[1], bz[1], fd[1], ur[1]}), 0);
    #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("after_reset_waits", int'({re[1], bz[1]}), 0);
    chk("sb_after_abort", sb.size(), 0);

    // three pixels with pixValid held high throughout
    begin_frame(1, 20);
    push_pix(24'hFF00AA, 24);
    push_pix(24'h0F0F0F, 24);
    push_pix(24'h123456, 24);
    push_ev(EV_FD);
    xb = xc[1];
    send_pix(1, 24'hFF00AA, 10, 1'b1);
    t0 = cyc;
    send_pix(1, 24'h0F0F0F, 10, 1'b1);
    send_pix(1, 24'h123456, 3200, 1'b1);
    pd[1] = 24'hDEAD00;
    wait_pulse(1, 1'b0, 7000);
    chk("three_frame_len", cyc - t0, 9000);
    pv[1] = 1'b0;
    @(negedge clk);
    chk("three_transfers", xc[1] - xb, 3);
    chk("three_idle", int'({bz[1], pr[1]}), 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wsb_frame_tx.md
WSB_FRAME_TX -- requirements
Module: wsb_frame_tx

Interface
REQ-001 Parameter TBIT, default 125, meaning clk cycles per data bit (1.25 us at 100 MHz).
REQ-002 Parameter T0H, default 40, meaning high cycles for a 0 bit (0.40 us).
REQ-003 Parameter T1H, default 80, meaning high cycles for a 1 bit (0.80 us).
REQ-004 Parameter NUM_LEDS, default 8, meaning pixels per frame; legal range 1..255.
REQ-005 Port clk, input, 1, meaning 100 MHz system clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, meaning asynchronous active-low reset; reset=0 clears all state immediately.
REQ-007 Port start, input, 1, meaning a one-cycle request to transmit one frame.
REQ-008 Port retEn, output, 1, meaning enable to the external RET timer.
REQ-009 Port retDone, input, 1, meaning RET timer reached 60 us; the timer holds it high for one cycle.
REQ-010 Port pixData, input, 24, meaning GRB pixel; G[23:16], R[15:8], B[7:0].
REQ-011 Port pixValid, input, 1, meaning pixData is valid.
REQ-012 Port pixReady, output, 1, meaning the block accepts pixData this cycle.
REQ-013 Port dout, output, 1, meaning serial line to the first WS2812B.
REQ-014 Port busy, output, 1, meaning a frame is in progress.
REQ-015 Port frameDone, output, 1, meaning a one-cycle pulse when the last bit of the frame completes.
REQ-016 Port underrun, output, 1, meaning a one-cycle pulse when the frame is aborted for lack of a pixel.

Function
REQ-017 The block SHALL use FSM states IDLE, RET, FETCH, SEND and DONE.
REQ-018 IDLE SHALL move to RET when start=1; start SHALL be ignored in every other state.
REQ-019 RET SHALL hold retEn=1 and SHALL move to FETCH in the cycle after retDone=1; retEn SHALL be 0 in all other states.
REQ-020 A transfer SHALL occur when pixValid and pixReady are both 1 on the same clk edge.
REQ-021 FETCH SHALL hold pixReady=1 and dout=0 until a transfer; the transfer SHALL load the shift register and enter SEND.
REQ-022 FETCH SHALL have no timeout; the first pixel of a frame may stall indefinitely.
REQ-023 SEND SHALL shift each pixel MSB-first (bit 23 first) through 24 bits.
REQ-024 Each bit SHALL last exactly TBIT cycles, with dout=1 for cycles 0..TH-1 and dout=0 for the remainder, where TH=T1H for a 1 bit and TH=T0H for a 0 bit.
REQ-025 Successive bits and pixels SHALL be contiguous, with no idle cycles between them.
REQ-026 The block SHALL have a one-entry holding register for the next pixel.
REQ-027 While in SEND, if the holding register is empty and the current pixel is not the last, pixReady SHALL be 1.
REQ-028 At the end of bit 0 of a non-last pixel, the holding register SHALL move to the shift register with no gap.
REQ-029 If the holding register is empty at that point, the block SHALL pulse underrun, drive dout=0 and return to IDLE without asserting frameDone.
REQ-030 After bit 0 of pixel NUM_LEDS-1 the block SHALL enter DONE, pulse frameDone for one cycle and return to IDLE.
REQ-031 The pixel counter SHALL be 8 bits and the bit index 5 bits.
REQ-032 The cycle counter SHALL be 8 bits and count 0..TBIT-1, then wrap to 0.
REQ-033 busy SHALL be 1 in RET, FETCH, SEND and DONE.
REQ-034 pixReady SHALL be 0 in IDLE, RET and DONE.
REQ-035 The transfer of pixel N+1 and the end of bit 0 of pixel N on the same edge SHALL be handled as "holding register full": no underrun.

Reset
REQ-036 While reset=0, the block SHALL hold state IDLE, all counters and registers at 0, and dout, retEn, pixReady, busy, frameDone and underrun at 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no frameDone or underrun pulse.
REQ-038 After reset release, the block SHALL wait for a new start.

Structure
REQ-039 The state encoding and the default values of TBIT, T0H and T1H SHALL reside in shared package wsb_pkg.
REQ-040 Per-bit waveform generation SHALL be one sub-module, wsb_bit_gen (inputs: bit value, go; outputs: dout, bitDone).

Verification
REQ-041 Scenario: reset, start, retDone pulsed 6000 cycles later -> retEn high for exactly those cycles, then pixReady=1.
REQ-042 Scenario: NUM_LEDS=1, pixel 24'hA50000 -> dout widths 80/45 for 1 bits and 40/85 for 0 bits, MSB first, total 3000 cycles, frameDone once.
REQ-043 Scenario: NUM_LEDS=3, pixValid always 1 -> 9000 contiguous cycles, exactly 3 transfers, no underrun.
REQ-044 Scenario: NUM_LEDS=3, second pixel withheld -> underrun pulse at cycle 3000 of SEND, dout=0, busy=0, no frameDone.
REQ-045 Scenario: start asserted again mid-frame -> ignored, frame unaffected.
REQ-046 Scenario: reset=0 during bit 10 of pixel 1 -> all outputs 0 immediately, no pulses, and the next start behaves normally.
